lcd_rgb_rx: RTL and testbench

Receiver for the parallel RGB LCD interface (DE/HS/VS/RGB888) that the display path generates. It sits on the capture side, for example in a loopback bench or a second board reading the panel bus. It recovers per-pixel coordinates, measures active resolution, and declares lock after consecutive frames match the expected 800x480 geometry. It supports self-checking of the display pipeline against the known panel timing.

---
 rtl/lcd_rgb_rx.sv | 198 +++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: parallel RGB LCD capture with pixel coordinates, geometry measurement and lock.
// Define LCD_RX_CHKSUM_EN to add the per-frame XOR checksum output frame_chksum.
module lcd_rgb_rx #(
    parameter int H_DISP      = 800,
    parameter int V_DISP      = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        lcd_de,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic [23:0] lcd_rgb,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic        locked,
    output logic        frame_err
`ifdef LCD_RX_CHKSUM_EN
    ,
    output logic [23:0] frame_chksum
`endif
);

    localparam logic [10:0] XMAX   = 11'h7FF;
    localparam logic [10:0] H_EXP  = 11'(H_DISP);
    localparam logic [10:0] V_EXP  = 11'(V_DISP);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [23:0] WD_MAX = 24'(TIMEOUT);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic        de_q, hs_q, vs_q, de_p_q, hs_p_q, vs_p_q;
    logic [23:0] rgb_q;
    logic        valid_q, fs_q, err_q, err_d, bad_q, bad_d;
    logic [23:0] data_q;
    logic [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [10:0] hact_q, hact_d, vact_q, vact_d, lines_q, lines_d;
    logic [23:0] wd_q, wd_d;
    logic [3:0]  good_q, good_d;
    state_t      state_q, state_d;

    logic        de_rise, de_fall, hs_fall, vs_fall, close_line, line_bad, bad_cl, frame_bad;
    logic [10:0] last_x, line_len, lines_cl;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == XMAX) ? v : v + 11'd1;
    endfunction

    // Input capture plus one cycle of history for edge detection; idle bus at reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= '0;
            de_p_q <= 1'b0;
            hs_p_q <= 1'b1;
            vs_p_q <= 1'b1;
        end else begin
            de_q   <= lcd_de;
            hs_q   <= lcd_hs;
            vs_q   <= lcd_vs;
            rgb_q  <= lcd_rgb;
            de_p_q <= de_q;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
        end
    end

    assign de_rise = de_q & ~de_p_q;
    assign de_fall = ~de_q & de_p_q;
    assign hs_fall = ~hs_q & hs_p_q;
    assign vs_fall = ~vs_q & vs_p_q;

    always_comb begin
        xpos_d = xpos_q;
        if (de_q) xpos_d = de_rise ? 11'd0 : sat_inc(xpos_q);
        // A line still in DE at VS fall is closed with the pixel of this cycle included.
        close_line = de_fall | (vs_fall & de_q);
        last_x     = de_fall ? xpos_q : xpos_d;
        line_len   = sat_inc(last_x);
        line_bad   = (last_x == XMAX) || (line_len != H_EXP);
        lines_cl   = close_line ? sat_inc(lines_q) : lines_q;
        bad_cl     = bad_q | (close_line & line_bad) | (hs_fall & de_q);
        frame_bad  = bad_cl | (lines_cl != V_EXP);
        hact_d     = close_line ? line_len : hact_q;
        vact_d     = vs_fall ? lines_cl : vact_q;
        ypos_d     = vs_fall ? 11'd0 : (close_line ? sat_inc(ypos_q) : ypos_q);
        lines_d    = vs_fall ? 11'd0 : lines_cl;
        bad_d      = vs_fall ? 1'b0 : bad_cl;
        wd_d       = vs_fall ? 24'd0 : ((wd_q == WD_MAX) ? wd_q : wd_q + 24'd1);
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (wd_q == WD_MAX && !vs_fall) begin
            state_d = SEARCH;
            good_d  = 4'd0;
        end else if (vs_fall) begin
            case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    good_d  = 4'd0;
                end
                MEASURE: begin
                    if (frame_bad) begin
                        good_d = 4'd0;
                        err_d  = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_d >= LOCK_N) state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_bad) begin
                        state_d = MEASURE;
                        good_d  = 4'd0;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            fs_q    <= 1'b0;
            hact_q  <= '0;
            vact_q  <= '0;
            lines_q <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            good_q  <= '0;
            state_q <= SEARCH;
        end else begin
            valid_q <= de_q;
            data_q  <= rgb_q;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            fs_q    <= vs_fall;
            hact_q  <= hact_d;
            vact_q  <= vact_d;
            lines_q <= lines_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            good_q  <= good_d;
            state_q <= state_d;
        end
    end

    assign pixel_valid = valid_q;
    assign pixel_data  = data_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = fs_q;
    assign h_active    = hact_q;
    assign v_active    = vact_q;
    assign locked      = (state_q == LOCKED);
    assign frame_err   = err_q;

`ifdef LCD_RX_CHKSUM_EN
    logic [23:0] acc_q, acc_d, sum_q, sum_d, acc_nxt;

    always_comb begin
        acc_nxt = acc_q ^ (de_q ? rgb_q : 24'd0);
        acc_d   = vs_fall ? 24'd0 : acc_nxt;
        sum_d   = vs_fall ? acc_nxt : sum_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign frame_chksum = sum_q;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx on a scaled 8x4 geometry; pixel payload encodes {row, column}.
module tb_lcd_rgb_rx;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LF = 2;
    localparam int TO = 3000;
`ifdef LCD_RX_CHKSUM_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        lcd_de = 1'b0, lcd_hs = 1'b1, lcd_vs = 1'b1;
    logic [23:0] lcd_rgb = '0;
    logic        pixel_valid, frame_start, locked, frame_err;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos, pixel_ypos, h_active, v_active;
`ifdef LCD_RX_CHKSUM_EN
    logic [23:0] frame_chksum;
`endif

    int          n_chk = 0, n_pass = 0;
    bit          mon_en = 1'b0;
    logic        p_de = 1'b0;
    logic [23:0] p_rgb = '0;

    always #5 sys_clk = ~sys_clk;

    lcd_rgb_rx #(.H_DISP(H), .V_DISP(V), .LOCK_FRAMES(LF), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_rgb(lcd_rgb),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .frame_start(frame_start), .h_active(h_active), .v_active(v_active),
        .locked(locked), .frame_err(frame_err)
`ifdef LCD_RX_CHKSUM_EN
        , .frame_chksum(frame_chksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Launch one bus cycle just after a rising edge; outputs then reflect the previous launch.
    task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
        lcd_de = de; lcd_hs = hs; lcd_vs = vs; lcd_rgb = rgb;
        @(posedge sys_clk); #1;
        if (mon_en) begin
            chk("vld", pixel_valid, p_de);
            if (p_de) begin
                chk("data", pixel_data, p_rgb);
                chk("xpos", pixel_xpos, p_rgb[10:0]);
                chk("ypos", pixel_ypos, p_rgb[21:11]);
            end
        end
        p_de = de; p_rgb = rgb;
    endtask

    task automatic vsync(input bit c, input bit lk, input bit er, input int v);
        cyc(0, 1, 0, 0);
        if (c) chk("fs_pre", frame_start, 0);
        cyc(0, 1, 0, 0);
        if (c) begin
            chk("fs", frame_start, 1);
            chk("locked", locked, lk);
            chk("ferr", frame_err, er);
            if (v >= 0) chk("vact", v_active, v);
        end
        cyc(0, 1, 1, 0);
        if (c) begin
            chk("fs_post", frame_start, 0);
            chk("ferr_post", frame_err, 0);
        end
        cyc(0, 1, 1, 0);
    endtask

    task automatic send_row(input int r, input int len, input int hsb, input bit pat, input int gap);
        int xs;
        logic [23:0] d;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        for (int x = 0; x < len; x++) begin
            xs = (x > 2047) ? 2047 : x;
            d  = pat ? ((r == 1 && x == 2) ? 24'h000001 : 24'hA5A5A5) : {2'b00, 11'(r), 11'(xs)};
            cyc(1, (x == hsb) ? 1'b0 : 1'b1, 1, d);
        end
        repeat (gap) cyc(0, 1, 1, 0);
    endtask

    task automatic send_frame(input bit c, input bit lk, input bit er, input int v,
                              input int srow, input int hrow, input int lrow, input int tail, input bit pat);
        vsync(c, lk, er, v);
        for (int r = 0; r < V; r++)
            send_row(r, (r == srow) ? H - 1 : ((r == lrow) ? 2050 : H), (r == hrow) ? 3 : -1,
                     pat, (r == V - 1) ? tail : 2);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_vld", pixel_valid, 0);
        chk("rst_lk", locked, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_hact", h_active, 0);
        chk("rst_vact", v_active, 0);
        sys_rst_n = 1'b1;
        cyc(0, 1, 1, 0);

        // two-edge latency and h_active of a single-pixel line
        cyc(1, 1, 1, 24'h123456);
        chk("lat0_vld", pixel_valid, 0);
        cyc(0, 1, 1, 0);
        chk("lat_vld", pixel_valid, 1);
        chk("lat_data", pixel_data, 24'h123456);
        chk("lat_x", pixel_xpos, 0);
        chk("lat_hact0", h_active, 0);
        cyc(0, 1, 1, 0);
        chk("lat_vld_off", pixel_valid, 0);
        chk("lat_hact", h_active, 1);

        mon_en = 1'b1;
        send_frame(1, 0, 0, 1, -1, -1, -1, 2, 0);  // leaves SEARCH, no evaluation
        chk("hact_nom", h_active, H);
        send_frame(1, 0, 0, V, -1, -1, -1, 2, 0);
        send_frame(1, 1, 0, V, -1, -1, -1, 2, 0);  // lock on 3rd VS fall
        send_frame(1, 1, 0, V, 3, -1, -1, 2, 0);   // short last line
        chk("hact_short", h_active, H - 1);
        send_frame(1, 0, 1, V, -1, -1, -1, 2, 0);
        send_frame(1, 0, 0, V, -1, 1, -1, 2, 0);   // HS fall inside DE
        send_frame(1, 0, 1, V, -1, -1, -1, 2, 0);
        send_frame(1, 0, 0, V, -1, -1, -1, 2, 0);
        send_frame(1, 1, 0, V, -1, -1, -1, 0, 0);  // last DE fall coincides with VS fall
        vsync(1, 1, 0, V);

        repeat (TO - 20) cyc(0, 1, 1, 0);
        chk("wd_before", locked, 1);
        repeat (40) cyc(0, 1, 1, 0);
        chk("wd_after", locked, 0);

        send_frame(1, 0, 0, 0, -1, -1, 3, 2, 0);   // SEARCH: no frame_err; long last line
        chk("long_x", pixel_xpos, 2047);
        chk("long_hact", h_active, 2047);
        send_frame(1, 0, 1, V, -1, -1, -1, 2, 0);
        send_frame(1, 0, 0, V, -1, -1, -1, 2, 0);

        // async reset in the middle of line 1
        vsync(1, 1, 0, V);
        send_row(0, H, -1, 0, 2);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        for (int x = 0; x < 4; x++) cyc(1, 1, 1, {2'b00, 11'd1, 11'(x)});
        mon_en = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk("mrst_vld", pixel_valid, 0);
        chk("mrst_data", pixel_data, 0);
        chk("mrst_x", pixel_xpos, 0);
        chk("mrst_y", pixel_ypos, 0);
        chk("mrst_lk", locked, 0);
        chk("mrst_hact", h_active, 0);
        chk("mrst_vact", v_active, 0);
        for (int x = 4; x < 7; x++) cyc(1, 1, 1, {2'b00, 11'd1, 11'(x)});
        sys_rst_n = 1'b1;
        cyc(1, 1, 1, {2'b00, 11'd1, 11'd7});
        repeat (2) cyc(0, 1, 1, 0);
        send_row(2, H, -1, 0, 2);
        send_row(3, H, -1, 0, 2);

        mon_en = 1'b1;
        send_frame(1, 0, 0, -1, -1, -1, -1, 2, 0);
        send_frame(1, 0, 0, V, -1, -1, -1, 2, 0);
        mon_en = !PAT_EN;
        send_frame(1, 1, 0, V, -1, -1, -1, 2, PAT_EN);
        vsync(1, 1, 0, V);
`ifdef LCD_RX_CHKSUM_EN
        chk("chksum", frame_chksum, 24'hA5A5A4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
